// File: rtl/pipeline_ctrl.sv
// Pause/flush scheduler for the six back-end pipeline registers, plus front-end redirect and idle-wait control.
// Optional build macro PIPE_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipeline_ctrl #(
    parameter int STAGES = 6,
    parameter int EX_IDX = 3,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] pause_req,
    input  logic              br_redirect,
    input  logic [PC_W-1:0]   br_target,
    input  logic              exc_commit,
    input  logic [PC_W-1:0]   exc_target,
    input  logic              idle_commit,
    input  logic [PC_W-1:0]   idle_pc,
    input  logic              int_pending,
    input  logic              redirect_ready,
    output logic [STAGES-1:0] pause_o,
    output logic [STAGES-1:0] flush_o,
    output logic [PC_W-1:0]   new_pc,
    output logic              new_pc_valid,
    output logic              idle_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        IDLE     = 2'd2
    } state_t;

    localparam logic [STAGES-1:0] EX_MASK  = STAGES'((1 << (EX_IDX + 1)) - 1);
    localparam logic [STAGES-1:0] FE_MASK  = STAGES'(3);
    localparam logic [STAGES-1:0] ONE_MASK = STAGES'(1);

    state_t            state_p1, state_d;
    logic [PC_W-1:0]   new_pc_p1, new_pc_d;
    logic              vld_p1, vld_d;
    logic              idle_p1, idle_d;
    logic [STAGES-1:0] pause_c, flush_c;
    logic [2*STAGES-1:0] stall_v;
    logic              br_acc;

    // Stall rule over registers lo..STAGES-1: pause up to the highest requester,
    // inject a bubble into the register just above it. Returns {flush, pause}.
    function automatic logic [2*STAGES-1:0] stall_rule(input logic [STAGES-1:0] req,
                                                       input int lo);
        logic [STAGES-1:0] p;
        logic [STAGES-1:0] f;
        int h;
        p = '0;
        f = '0;
        h = -1;
        for (int k = 0; k < STAGES; k++) begin
            if (k >= lo && req[k]) h = k;
        end
        for (int k = 0; k < STAGES; k++) begin
            if (k >= lo && k <= h) p[k] = 1'b1;
            if (h >= 0 && k == h + 1) f[k] = 1'b1;
        end
        return {f, p};
    endfunction

    always_comb begin
        pause_c = '0;
        flush_c = '0;
        stall_v = '0;
        br_acc  = 1'b0;
        if (exc_commit || idle_commit) begin
            flush_c = '1;
        end else if (state_p1 == IDLE) begin
            pause_c = ONE_MASK;
            flush_c = ~ONE_MASK;
        end else if (br_redirect) begin
            br_acc  = 1'b1;
            stall_v = stall_rule(pause_req, EX_IDX + 1);
            pause_c = stall_v[STAGES-1:0];
            flush_c = stall_v[2*STAGES-1:STAGES] | EX_MASK;
        end else if (state_p1 == REDIRECT) begin
            stall_v = stall_rule(pause_req, 2);
            pause_c = stall_v[STAGES-1:0] | FE_MASK;
            flush_c = stall_v[2*STAGES-1:STAGES];
        end else begin
            stall_v = stall_rule(pause_req, 0);
            pause_c = stall_v[STAGES-1:0];
            flush_c = stall_v[2*STAGES-1:STAGES];
        end
    end

    // Flush always wins over pause on the same register.
    assign pause_o = pause_c & ~flush_c;
    assign flush_o = flush_c;

    always_comb begin
        state_d  = state_p1;
        new_pc_d = new_pc_p1;
        vld_d    = vld_p1;
        idle_d   = idle_p1;
        if (exc_commit) begin
            new_pc_d = exc_target;
            vld_d    = 1'b1;
            idle_d   = 1'b0;
            state_d  = REDIRECT;
        end else if (idle_commit) begin
            new_pc_d = idle_pc + PC_W'(4);
            vld_d    = 1'b0;
            idle_d   = 1'b1;
            state_d  = IDLE;
        end else begin
            unique case (state_p1)
                IDLE: begin
                    if (int_pending) begin
                        vld_d   = 1'b1;
                        idle_d  = 1'b0;
                        state_d = REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (br_redirect) begin
                        new_pc_d = br_target;
                        vld_d    = 1'b1;
                    end else if (redirect_ready) begin
                        vld_d   = 1'b0;
                        state_d = RUN;
                    end
                end
                default: begin
                    if (br_redirect) begin
                        new_pc_d = br_target;
                        vld_d    = 1'b1;
                        state_d  = REDIRECT;
                    end
                end
            endcase
        end
    end

    // Registered redirect/idle stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1  <= RUN;
            new_pc_p1 <= '0;
            vld_p1    <= 1'b0;
            idle_p1   <= 1'b0;
        end else begin
            state_p1  <= state_d;
            new_pc_p1 <= new_pc_d;
            vld_p1    <= vld_d;
            idle_p1   <= idle_d;
        end
    end

    assign new_pc       = new_pc_p1;
    assign new_pc_valid = vld_p1;
    assign idle_o       = idle_p1;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_p1, flush_cnt_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (|pause_o) stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
            if (exc_commit || idle_commit || br_acc) flush_cnt_p1 <= flush_cnt_p1 + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_p1;
    assign flush_events = flush_cnt_p1;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: table of combinational vectors plus multi-cycle sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pause_req;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        exc_commit;
    logic [31:0] exc_target;
    logic        idle_commit;
    logic [31:0] idle_pc;
    logic        int_pending;
    logic        redirect_ready;
    logic [5:0]  pause_o;
    logic [5:0]  flush_o;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic        idle_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    int tests = 0;
    int fails = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .pause_req(pause_req),
        .br_redirect(br_redirect), .br_target(br_target),
        .exc_commit(exc_commit), .exc_target(exc_target),
        .idle_commit(idle_commit), .idle_pc(idle_pc),
        .int_pending(int_pending), .redirect_ready(redirect_ready),
        .pause_o(pause_o), .flush_o(flush_o), .new_pc(new_pc),
        .new_pc_valid(new_pc_valid), .idle_o(idle_o)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [5:0] req;
        logic       br;
        logic       exc;
        logic       idl;
        logic [5:0] ep;
        logic [5:0] ef;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pause_req      = '0;
        br_redirect    = 1'b0;
        br_target      = '0;
        exc_commit     = 1'b0;
        exc_target     = '0;
        idle_commit    = 1'b0;
        idle_pc        = '0;
        int_pending    = 1'b0;
        redirect_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"stall_mid",   6'b000100, 0, 0, 0, 6'b000111, 6'b001000};
        vecs[1] = '{"stall_none",  6'b000000, 0, 0, 0, 6'b000000, 6'b000000};
        vecs[2] = '{"stall_top",   6'b100000, 0, 0, 0, 6'b111111, 6'b000000};
        vecs[3] = '{"stall_if",    6'b000001, 0, 0, 0, 6'b000001, 6'b000010};
        vecs[4] = '{"stall_multi", 6'b010010, 0, 0, 0, 6'b011111, 6'b100000};
        vecs[5] = '{"stall_ex",    6'b001001, 0, 0, 0, 6'b001111, 6'b010000};
        vecs[6] = '{"br_low_req",  6'b000100, 1, 0, 0, 6'b000000, 6'b001111};
        vecs[7] = '{"br_mem_req",  6'b010000, 1, 0, 0, 6'b010000, 6'b101111};
        vecs[8] = '{"br_wb_req",   6'b100000, 1, 0, 0, 6'b110000, 6'b001111};
        vecs[9] = '{"exc_over",    6'b111111, 1, 1, 1, 6'b000000, 6'b111111};

        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        check("rst_pause", 32'(pause_o), 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_valid", 32'(new_pc_valid), 32'h0);
        check("rst_idle", 32'(idle_o), 32'h0);

        for (int i = 0; i < 10; i++) begin
            pause_req   = vecs[i].req;
            br_redirect = vecs[i].br;
            exc_commit  = vecs[i].exc;
            idle_commit = vecs[i].idl;
            #1;
            check({vecs[i].nm, "_pause"}, 32'(pause_o), 32'(vecs[i].ep));
            check({vecs[i].nm, "_flush"}, 32'(flush_o), 32'(vecs[i].ef));
            tick();
            do_reset();
        end

        // Branch redirect held while IF is not ready
        br_redirect = 1'b1;
        br_target   = 32'h1c00_0100;
        #1;
        check("br_pulse_flush", 32'(flush_o), 32'h0f);
        tick();
        br_redirect = 1'b0;
        br_target   = 32'hdead_beef;
        #1;
        check("redir_pause", 32'(pause_o), 32'h03);
        for (int i = 0; i < 3; i++) begin
            check("redir_valid_hold", 32'(new_pc_valid), 32'h1);
            check("redir_pc_hold", new_pc, 32'h1c00_0100);
            tick();
        end
        redirect_ready = 1'b1;
        check("redir_valid_c4", 32'(new_pc_valid), 32'h1);
        tick();
        redirect_ready = 1'b0;
        #1;
        check("redir_valid_drop", 32'(new_pc_valid), 32'h0);
        check("redir_back_run", 32'(pause_o), 32'h0);

        // Exception beats simultaneous branch
        exc_commit  = 1'b1;
        exc_target  = 32'h1c00_8000;
        br_redirect = 1'b1;
        br_target   = 32'h1c00_0200;
        #1;
        check("exc_br_flush", 32'(flush_o), 32'h3f);
        check("exc_br_pause", 32'(pause_o), 32'h0);
        tick();
        clear_inputs();
        check("exc_br_pc", new_pc, 32'h1c00_8000);
        check("exc_br_valid", 32'(new_pc_valid), 32'h1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        // Idle-wait then interrupt wake-up
        idle_commit = 1'b1;
        idle_pc     = 32'h1c00_0040;
        #1;
        check("idle_commit_flush", 32'(flush_o), 32'h3f);
        tick();
        clear_inputs();
        pause_req = 6'b111111;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_o_hold", 32'(idle_o), 32'h1);
            check("idle_pause", 32'(pause_o), 32'h01);
            check("idle_flush", 32'(flush_o), 32'h3e);
            check("idle_no_valid", 32'(new_pc_valid), 32'h0);
            tick();
        end
        int_pending = 1'b1;
        tick();
        int_pending = 1'b0;
        check("wake_pc", new_pc, 32'h1c00_0044);
        check("wake_valid", 32'(new_pc_valid), 32'h1);
        check("wake_idle_o", 32'(idle_o), 32'h0);

        // Reset while a redirect is pending
        pause_req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_redir_valid", 32'(new_pc_valid), 32'h0);
        check("rst_redir_pc", new_pc, 32'h0);
        check("rst_redir_pause", 32'(pause_o), 32'h0);
        check("rst_redir_idle", 32'(idle_o), 32'h0);

        // New branch arriving together with redirect_ready
        br_redirect = 1'b1;
        br_target   = 32'h1c00_1000;
        tick();
        br_target      = 32'h1c00_2000;
        redirect_ready = 1'b1;
        tick();
        br_redirect = 1'b0;
        check("ready_br_valid", 32'(new_pc_valid), 32'h1);
        check("ready_br_pc", new_pc, 32'h1c00_2000);
        tick();
        redirect_ready = 1'b0;
        check("ready_br_done", 32'(new_pc_valid), 32'h0);

`ifdef PIPE_PERF_CNT_EN
        do_reset();
        check("perf_rst_stall", stall_cycles, 32'h0);
        pause_req = 6'b000001;
        for (int i = 0; i < 5; i++) tick();
        pause_req = '0;
        check("perf_stall5", stall_cycles, 32'd5);
        exc_commit = 1'b1;
        exc_target = 32'h1c00_3000;
        tick();
        tick();
        exc_commit = 1'b0;
        check("perf_flush2", flush_events, 32'd2);
        check("perf_stall_keep", stall_cycles, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
